// File: rtl/demux_1x8.sv
// 1-to-8 demux: lane sel carries din, all other lanes zero; 1 cycle latency (REG_OUT=1) or 0 (REG_OUT=0).
// No backpressure: a new din/sel is accepted every cycle, never stalls.
module demux_1x8 #(
    parameter int WIDTH   = 1,
    parameter int REG_OUT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     din,
    input  logic [2:0]           sel,
    output logic [8*WIDTH-1:0]   y
);

    logic [8*WIDTH-1:0] y_d;

    // Decode and data are combined in one step so din and sel always land together.
    always_comb begin
        y_d = '0;
        for (int k = 0; k < 8; k++) begin
            if (sel == 3'(k)) begin
                y_d[k*WIDTH +: WIDTH] = din;
            end
        end
    end

    if (REG_OUT != 0) begin : g_reg
        logic [8*WIDTH-1:0] y_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                y_q <= '0;
            end else begin
                y_q <= y_d;
            end
        end

        assign y = y_q;
    end else begin : g_comb
        // Clock and reset are intentionally ignored in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign y = y_d;
    end

endmodule

// File: tb/tb_demux_1x8.sv
// Bench for demux_1x8: registered WIDTH=1 instance plus WIDTH=4 combinational and registered instances.
module tb_demux_1x8;

    logic        clk;
    logic        rst_n;
    logic [0:0]  din1;
    logic [2:0]  sel1;
    logic [7:0]  y1;
    logic [3:0]  din4;
    logic [2:0]  sel4;
    logic [31:0] y4c;
    logic [31:0] y4r;

    int n_checks;
    int n_fail;

    demux_1x8 #(.WIDTH(1), .REG_OUT(1)) dut (
        .clk(clk), .rst_n(rst_n), .din(din1), .sel(sel1), .y(y1)
    );

    demux_1x8 #(.WIDTH(4), .REG_OUT(0)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel4), .y(y4c)
    );

    demux_1x8 #(.WIDTH(4), .REG_OUT(1)) dut_r4 (
        .clk(clk), .rst_n(rst_n), .din(din4), .sel(sel4), .y(y4r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: eight lanes of width w, only lane s carries d.
    function automatic logic [31:0] model(input int w, input logic [3:0] d, input int s);
        logic [31:0] r;
        logic [31:0] lane;
        r = '0;
        lane = 32'(d) & ((32'd1 << w) - 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (k == s) r = r + lane * (32'd1 << (k * w));
        end
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b1;
        din1 = 1'b1; sel1 = 3'd2; din4 = 4'hF; sel4 = 3'd1;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (y1 !== 8'h00) begin
            n_fail++; $display("FAIL reset_async_y1 got=%h exp=%h", y1, 8'h00);
        end
        n_checks++;
        if (y4r !== 32'h0) begin
            n_fail++; $display("FAIL reset_async_y4r got=%h exp=%h", y4r, 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            din1 = 1'($urandom_range(1, 1)); sel1 = 3'($urandom);
            din4 = 4'($urandom_range(1, 15)); sel4 = 3'($urandom);
            @(posedge clk); #1;
            n_checks++;
            if (y1 !== 8'h00) begin
                n_fail++; $display("FAIL reset_hold_y1 cyc=%0d got=%h exp=%h", i, y1, 8'h00);
            end
            n_checks++;
            if (y4r !== 32'h0) begin
                n_fail++; $display("FAIL reset_hold_y4r cyc=%0d got=%h exp=%h", i, y4r, 32'h0);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        logic [7:0] exp;
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            din1 = 1'b1; sel1 = 3'(s);
            @(posedge clk); #1;
            exp = 8'd1 << s;
            n_checks++;
            if (y1 !== exp) begin
                n_fail++; $display("FAIL sweep sel=%0d got=%b exp=%b", s, y1, exp);
            end
        end
    endtask

    task automatic test_zero_data();
        @(negedge clk);
        din1 = 1'b0; sel1 = 3'd5;
        @(posedge clk); #1;
        n_checks++;
        if (y1 !== 8'h00) begin
            n_fail++; $display("FAIL zero_data got=%b exp=%b", y1, 8'h00);
        end
    endtask

    task automatic test_random_packing();
        logic [3:0]  r;
        logic [31:0] exp;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            r = 4'($urandom);
            din1 = r[3]; sel1 = r[2:0];
            @(posedge clk); #1;
            exp = model(1, {3'b000, r[3]}, int'(r[2:0]));
            n_checks++;
            if (y1 !== exp[7:0]) begin
                n_fail++; $display("FAIL random_pack cyc=%0d in=%h got=%b exp=%b", i, r, y1, exp[7:0]);
            end
        end
    endtask

    task automatic test_hold();
        logic [7:0] held;
        logic [31:0] exp;
        @(negedge clk);
        din1 = 1'b1; sel1 = 3'd4;
        @(posedge clk); #1;
        held = 8'h10;
        n_checks++;
        if (y1 !== held) begin
            n_fail++; $display("FAIL hold_load got=%b exp=%b", y1, held);
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            din1 = 1'($urandom); sel1 = 3'($urandom);
            n_checks++;
            if (y1 !== held) begin
                n_fail++; $display("FAIL hold_between_edges step=%0d got=%b exp=%b", i, y1, held);
            end
        end
        @(negedge clk);
        din1 = 1'b1; sel1 = 3'd6;
        #1;
        n_checks++;
        if (y1 !== held) begin
            n_fail++; $display("FAIL hold_before_edge got=%b exp=%b", y1, held);
        end
        @(posedge clk); #1;
        exp = model(1, 4'd1, 6);
        n_checks++;
        if (y1 !== exp[7:0]) begin
            n_fail++; $display("FAIL hold_next_edge got=%b exp=%b", y1, exp[7:0]);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] exp;
        @(negedge clk);
        din1 = 1'b1; sel1 = 3'd5;
        din4 = 4'h7; sel4 = 3'd2;
        @(posedge clk); #1;
        n_checks++;
        if (y1 !== 8'b0010_0000) begin
            n_fail++; $display("FAIL arst_preload got=%b exp=%b", y1, 8'b0010_0000);
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (y1 !== 8'h00) begin
            n_fail++; $display("FAIL arst_midcycle got=%b exp=%b", y1, 8'h00);
        end
        exp = model(4, 4'h7, 2);
        n_checks++;
        if (y4c !== exp) begin
            n_fail++; $display("FAIL comb_ignores_reset got=%h exp=%h", y4c, exp);
        end
        @(posedge clk); #1;
        n_checks++;
        if (y4r !== 32'h0) begin
            n_fail++; $display("FAIL arst_y4r_cleared got=%h exp=%h", y4r, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        din1 = 1'b1; sel1 = 3'd3;
        #1;
        n_checks++;
        if (y1 !== 8'h00) begin
            n_fail++; $display("FAIL arst_no_stale got=%b exp=%b", y1, 8'h00);
        end
        @(posedge clk); #1;
        n_checks++;
        if (y1 !== 8'b0000_1000) begin
            n_fail++; $display("FAIL arst_release got=%b exp=%b", y1, 8'b0000_1000);
        end
    endtask

    task automatic test_width4();
        logic [31:0] exp;
        logic [31:0] prev;
        @(negedge clk);
        din4 = 4'hA; sel4 = 3'd6;
        #1;
        n_checks++;
        if (y4c !== 32'h0A00_0000) begin
            n_fail++; $display("FAIL w4_comb got=%h exp=%h", y4c, 32'h0A00_0000);
        end
        @(posedge clk); #1;
        n_checks++;
        if (y4r !== 32'h0A00_0000) begin
            n_fail++; $display("FAIL w4_reg got=%h exp=%h", y4r, 32'h0A00_0000);
        end
        prev = 32'h0A00_0000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            din4 = 4'($urandom); sel4 = 3'($urandom);
            #1;
            exp = model(4, din4, int'(sel4));
            n_checks++;
            if (y4c !== exp) begin
                n_fail++; $display("FAIL w4_comb_rand cyc=%0d got=%h exp=%h", i, y4c, exp);
            end
            n_checks++;
            if (y4r !== prev) begin
                n_fail++; $display("FAIL w4_reg_latency cyc=%0d got=%h exp=%h", i, y4r, prev);
            end
            @(posedge clk); #1;
            n_checks++;
            if (y4r !== exp) begin
                n_fail++; $display("FAIL w4_reg_rand cyc=%0d got=%h exp=%h", i, y4r, exp);
            end
            prev = exp;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_sweep();
        test_zero_data();
        test_random_packing();
        test_hold();
        test_async_reset();
        test_width4();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
